// File: rtl/risc16_pkg.sv
// Shared types and constants for the RISC16 instruction-memory loader.
package risc16_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        StIdle,
        StLenHi,
        StLenLo,
        StDataHi,
        StDataLo,
        StCheck,
        StDone,
        StError
    } loader_state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_LEN     = 2'd1,
        ERR_CHK     = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_code_t;

    function automatic logic len_legal(input logic [15:0] len, input int unsigned depth);
        return (len != 16'd0) && (32'(len) <= depth);
    endfunction

endpackage

// File: rtl/risc16_load_timeout.sv
// Idle-cycle watchdog for an in-progress frame; expired fires on the TIMEOUT_CYC-th
// consecutive idle cycle unless clr is asserted in that same cycle.
module risc16_load_timeout #(
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] cnt_q;

    assign expired = en && !clr && (cnt_q == CW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (clr || !en || expired) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/risc16_imem_loader.sv
// Framed byte-stream loader for RISC16 imem: parses A5/LEN/data/CHK frames, writes words,
// and releases the core only after a frame passes its XOR checksum.
module risc16_imem_loader
    import risc16_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH  = 256,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        imem_we,
    output logic [15:0] imem_waddr,
    output logic [15:0] imem_wdata,
    output logic        core_run,
    output logic        done,
    output logic        error,
    output logic [1:0]  err_code
);

    loader_state_t state_q;
    err_code_t     err_q;
    logic [15:0]   len_q;
    logic [15:0]   count_q;
    logic [7:0]    hi_q;
    logic [7:0]    chk_q;
    logic          accept;
    logic          timeout_en;
    logic          timeout_hit;
    logic [15:0]   len_full;

    assign accept     = in_valid && in_ready;
    assign timeout_en = (state_q inside {StLenHi, StLenLo, StDataHi, StDataLo, StCheck});
    assign len_full   = {len_q[15:8], in_data};
    assign err_code   = err_q;

    risc16_load_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (accept),
        .en      (timeout_en),
        .expired (timeout_hit)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            err_q      <= ERR_NONE;
            len_q      <= '0;
            count_q    <= '0;
            hi_q       <= '0;
            chk_q      <= '0;
            in_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= '0;
            core_run   <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            in_ready <= 1'b1;
            imem_we  <= 1'b0;
            // timeout_hit is already masked by accept, so a late byte always wins
            if (timeout_hit) begin
                state_q <= StError;
                error   <= 1'b1;
                err_q   <= ERR_TIMEOUT;
            end else if (accept) begin
                unique case (state_q)
                    StIdle: begin
                        if (in_data == SYNC_BYTE) state_q <= StLenHi;
                    end
                    StLenHi: begin
                        len_q[15:8] <= in_data;
                        state_q     <= StLenLo;
                    end
                    StLenLo: begin
                        len_q <= len_full;
                        if (len_legal(len_full, IMEM_DEPTH)) begin
                            chk_q      <= '0;
                            count_q    <= '0;
                            imem_waddr <= '0;
                            state_q    <= StDataHi;
                        end else begin
                            state_q <= StError;
                            error   <= 1'b1;
                            err_q   <= ERR_LEN;
                        end
                    end
                    StDataHi: begin
                        hi_q    <= in_data;
                        chk_q   <= chk_q ^ in_data;
                        state_q <= StDataLo;
                    end
                    StDataLo: begin
                        imem_we    <= 1'b1;
                        imem_waddr <= count_q;
                        imem_wdata <= {hi_q, in_data};
                        chk_q      <= chk_q ^ in_data;
                        count_q    <= count_q + 16'd1;
                        state_q    <= (count_q + 16'd1 == len_q) ? StCheck : StDataHi;
                    end
                    StCheck: begin
                        if (in_data == chk_q) begin
                            state_q  <= StDone;
                            done     <= 1'b1;
                            error    <= 1'b0;
                            err_q    <= ERR_NONE;
                            core_run <= 1'b1;
                        end else begin
                            state_q <= StError;
                            error   <= 1'b1;
                            err_q   <= ERR_CHK;
                        end
                    end
                    StDone, StError: begin
                        if (in_data == SYNC_BYTE) begin
                            state_q  <= StLenHi;
                            core_run <= 1'b0;
                            done     <= 1'b0;
                            error    <= 1'b0;
                            err_q    <= ERR_NONE;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_risc16_imem_loader.sv
// Directed bench for risc16_imem_loader: table of whole frames plus hand-written timeout,
// mid-frame reset and reload sequences.
module tb_risc16_imem_loader;

    localparam int unsigned IMEM_DEPTH  = 256;
    localparam int unsigned TIMEOUT_CYC = 16;
    localparam int          NVEC        = 5;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        imem_we;
    logic [15:0] imem_waddr;
    logic [15:0] imem_wdata;
    logic        core_run;
    logic        done;
    logic        error;
    logic [1:0]  err_code;

    int n_cmp = 0;
    int n_bad = 0;
    int we_count = 0;

    typedef struct {
        logic [127:0] frame;   // bytes left-aligned, first byte in [127:120]
        int           nbytes;
        int           first_data;
        int           nw;
        logic [63:0]  w;       // expected words, word 0 in [63:48]
        logic         exp_done;
        logic         exp_err;
        logic [1:0]   exp_code;
        logic         exp_run;
    } vec_t;

    vec_t vecs [NVEC];

    risc16_imem_loader #(
        .IMEM_DEPTH  (IMEM_DEPTH),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .core_run   (core_run),
        .done       (done),
        .error      (error),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we === 1'b1) we_count++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n  = 1'b0;
        in_valid = 1'b0;
        #1;
        check("reset_outs", {in_ready, imem_we, imem_waddr, imem_wdata, core_run, done, error,
                             err_code}, 64'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_release", in_ready, 1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input int idx);
        vec_t v;
        v = vecs[idx];
        we_count = 0;
        for (int i = 0; i < v.nbytes; i++) begin
            int   rel;
            int   k;
            logic is_lo;
            rel = i - v.first_data;
            if (i == v.nbytes - 1) check($sformatf("v%0d_run_before_last", idx), core_run, 0);
            send_byte(v.frame[127 - 8*i -: 8]);
            is_lo = (rel >= 1) && ((rel % 2) == 1) && ((rel / 2) < v.nw);
            check($sformatf("v%0d_we_byte%0d", idx, i), imem_we, is_lo);
            if (is_lo) begin
                k = rel / 2;
                check($sformatf("v%0d_waddr%0d", idx, k), imem_waddr, k);
                check($sformatf("v%0d_wdata%0d", idx, k), imem_wdata, v.w[63 - 16*k -: 16]);
            end
        end
        check($sformatf("v%0d_done", idx), done, v.exp_done);
        check($sformatf("v%0d_error", idx), error, v.exp_err);
        check($sformatf("v%0d_err_code", idx), err_code, v.exp_code);
        check($sformatf("v%0d_core_run", idx), core_run, v.exp_run);
        @(negedge clk);
        check($sformatf("v%0d_we_count", idx), we_count, v.nw);
    endtask

    initial begin
        vecs[0] = '{{80'hA5_00_03_12_34_56_78_9A_BC_2E, 48'h0}, 10, 3, 3,
                   64'h1234_5678_9ABC_0000, 1'b1, 1'b0, 2'd0, 1'b1};
        vecs[1] = '{{80'hA5_00_03_12_34_56_78_9A_BC_2F, 48'h0}, 10, 3, 3,
                   64'h1234_5678_9ABC_0000, 1'b0, 1'b1, 2'd2, 1'b0};
        vecs[2] = '{{24'hA5_00_00, 104'h0}, 3, 3, 0, 64'h0, 1'b0, 1'b1, 2'd1, 1'b0};
        vecs[3] = '{{24'hA5_01_01, 104'h0}, 3, 3, 0, 64'h0, 1'b0, 1'b1, 2'd1, 1'b0};
        vecs[4] = '{{72'h00_FF_5A_A5_00_01_BE_EF_51, 56'h0}, 9, 6, 1,
                   64'hBEEF_0000_0000_0000, 1'b1, 1'b0, 2'd0, 1'b1};

        for (int i = 0; i < NVEC; i++) begin
            do_reset();
            send_frame(i);
        end

        // Timeout on the 16th idle cycle after the last accepted byte.
        do_reset();
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h02);
        repeat (15) @(posedge clk);
        #1;
        check("to_idle15_error", error, 0);
        @(posedge clk);
        #1;
        check("to_idle16_error", error, 1);
        check("to_idle16_code", err_code, 2'd3);
        check("to_idle16_run", core_run, 0);

        // A byte arriving on the 16th cycle beats the timeout and restarts the count.
        do_reset();
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h02);
        repeat (15) @(posedge clk);
        #1;
        send_byte(8'h11);
        check("to_race_error", error, 0);
        check("to_race_code", err_code, 2'd0);
        repeat (15) @(posedge clk);
        #1;
        check("to_restart15_error", error, 0);
        @(posedge clk);
        #1;
        check("to_restart16_code", err_code, 2'd3);

        // Asynchronous reset mid-frame, then a clean load and a reload from DONE.
        do_reset();
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h12);
        send_byte(8'h34);
        check("mid_we_before_reset", imem_we, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_reset_outs", {in_ready, imem_we, imem_waddr, imem_wdata, core_run, done,
                                 error, err_code}, 64'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("mid_ready_after_release", in_ready, 1);
        send_frame(0);
        send_byte(8'hA5);
        check("reload_run_dropped", core_run, 0);
        check("reload_done_dropped", done, 0);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'hBE);
        send_byte(8'hEF);
        check("reload_we", imem_we, 1);
        check("reload_waddr", imem_waddr, 16'h0000);
        check("reload_wdata", imem_wdata, 16'hBEEF);
        send_byte(8'h51);
        check("reload_done", done, 1);
        check("reload_run", core_run, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
